// File: rtl/block_stream_emitter_pkg.sv
// Shared definitions for the begin/end keyword stream emitter and its
// companion block-balance checker.
//   - Command encodings (OPEN/CLOSE/SPACE/FLUSH)
//   - ASCII constants for the keyword letters and the separator
//   - Emitter FSM state encoding
//   - Case helper used by the word ROM
package block_stream_emitter_pkg;

  typedef enum logic [1:0] {
    CMD_OPEN  = 2'b00,
    CMD_CLOSE = 2'b01,
    CMD_SPACE = 2'b10,
    CMD_FLUSH = 2'b11
  } cmd_e;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  localparam logic [7:0] C_b     = 8'h62;
  localparam logic [7:0] C_e     = 8'h65;
  localparam logic [7:0] C_g     = 8'h67;
  localparam logic [7:0] C_i     = 8'h69;
  localparam logic [7:0] C_n     = 8'h6E;
  localparam logic [7:0] C_d     = 8'h64;
  localparam logic [7:0] C_space = 8'h20;

  // Distance between lowercase and uppercase ASCII letters.
  localparam logic [7:0] CASE_SHIFT = 8'd32;

  // Longest word is "begin"+SEP = 6 chars, so 3 index bits suffice.
  localparam int unsigned IDX_W = 3;

  function automatic logic [7:0] to_case(input logic [7:0] c, input logic upper);
    return upper ? (c - CASE_SHIFT) : c;
  endfunction

endpackage

// File: rtl/block_stream_emitter_rom.sv
// block_word_rom: combinational character table for the emitter.
//   kind_i  : latched command (FLUSH emits the same word as CLOSE)
//   idx_i   : character position within the word
//   upper_i : 1 = letters shifted to uppercase (separator never shifted)
//   char_o  : character at idx_i
//   last_o  : idx_i addresses the final character (the separator)
module block_word_rom
  import block_stream_emitter_pkg::*;
#(
  parameter logic [7:0] SEP_CHAR = 8'd32
) (
  input  cmd_e             kind_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic             upper_i,
  output logic [7:0]       char_o,
  output logic             last_o
);

  logic [7:0] letter;
  logic       is_letter;

  always_comb begin
    letter    = '0;
    is_letter = 1'b0;
    last_o    = 1'b0;
    unique case (kind_i)
      CMD_OPEN: begin
        is_letter = 1'b1;
        case (idx_i)
          3'd0:    letter = C_b;
          3'd1:    letter = C_e;
          3'd2:    letter = C_g;
          3'd3:    letter = C_i;
          3'd4:    letter = C_n;
          default: begin
            is_letter = 1'b0;
            last_o    = 1'b1;
          end
        endcase
      end
      CMD_CLOSE, CMD_FLUSH: begin
        is_letter = 1'b1;
        case (idx_i)
          3'd0:    letter = C_e;
          3'd1:    letter = C_n;
          3'd2:    letter = C_d;
          default: begin
            is_letter = 1'b0;
            last_o    = 1'b1;
          end
        endcase
      end
      CMD_SPACE: begin
        last_o = 1'b1;
      end
    endcase
    char_o = is_letter ? to_case(letter, upper_i) : SEP_CHAR;
  end

endmodule

// File: rtl/block_stream_emitter.sv
// block_stream_emitter: command-driven generator of begin/end keyword text,
// one ASCII character per cycle, tracking nesting depth so the stream never
// contains an unmatched "end".
//   clk, reset      : rising-edge clock, asynchronous active-high reset
//   cmd_valid/cmd   : command in (00 OPEN, 01 CLOSE, 10 SPACE, 11 FLUSH)
//   cmd_upper       : letters of this command emitted in uppercase
//   cmd_ready       : command accepted this cycle (high only in IDLE)
//   out_char/valid  : character stream out, held stable while stalled
//   out_ready       : sink consumes out_char this cycle
//   depth/balanced  : open-block count and depth==0
//   err             : one-cycle pulse after a rejected command
module block_stream_emitter
  import block_stream_emitter_pkg::*;
#(
  parameter int unsigned DEPTH_W  = 8,
  parameter logic [7:0]  SEP_CHAR = 8'd32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  input  logic [1:0]         cmd,
  input  logic               cmd_upper,
  output logic               cmd_ready,
  output logic [7:0]         out_char,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DEPTH_W-1:0] depth,
  output logic               balanced,
  output logic               err
);

  state_e             state_q, state_d;
  cmd_e               kind_q, kind_d;
  logic               upper_q, upper_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               err_q, err_d;

  cmd_e               cmd_in;
  logic               cmd_fire;
  logic               char_fire;
  logic               start_emit;
  logic [7:0]         rom_char;
  logic               rom_last;

  assign cmd_in    = cmd_e'(cmd);
  assign cmd_ready = (state_q == IDLE);
  assign out_valid = (state_q == EMIT);
  assign cmd_fire  = cmd_valid & cmd_ready;
  assign char_fire = out_valid & out_ready;

  block_word_rom #(
    .SEP_CHAR (SEP_CHAR)
  ) u_rom (
    .kind_i  (kind_q),
    .idx_i   (idx_q),
    .upper_i (upper_q),
    .char_o  (rom_char),
    .last_o  (rom_last)
  );

  // Output is a function of registered state only, so the first character
  // appears the cycle after acceptance and holds while idx_q is stalled.
  assign out_char = out_valid ? rom_char : '0;
  assign depth    = depth_q;
  assign balanced = (depth_q == '0);
  assign err      = err_q;

  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    upper_d    = upper_q;
    idx_d      = idx_q;
    depth_d    = depth_q;
    err_d      = 1'b0;
    start_emit = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          unique case (cmd_in)
            CMD_OPEN: begin
              if (depth_q == '1) begin
                err_d = 1'b1;
              end else begin
                depth_d    = depth_q + DEPTH_W'(1);
                start_emit = 1'b1;
              end
            end
            CMD_CLOSE: begin
              if (depth_q == '0) begin
                err_d = 1'b1;
              end else begin
                depth_d    = depth_q - DEPTH_W'(1);
                start_emit = 1'b1;
              end
            end
            CMD_SPACE: begin
              start_emit = 1'b1;
            end
            CMD_FLUSH: begin
              // Nothing open: consumed silently, not an error.
              start_emit = (depth_q != '0);
            end
          endcase
          if (start_emit) begin
            state_d = EMIT;
            kind_d  = cmd_in;
            upper_d = cmd_upper;
            idx_d   = '0;
          end
        end
      end
      EMIT: begin
        if (char_fire) begin
          if (rom_last) begin
            if (kind_q == CMD_FLUSH) begin
              // FLUSH closes one block per "end"+SEP group and loops the
              // same word until the last open block is closed.
              depth_d = depth_q - DEPTH_W'(1);
              idx_d   = '0;
              if (depth_q == DEPTH_W'(1)) begin
                state_d = IDLE;
              end
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      kind_q  <= CMD_OPEN;
      upper_q <= 1'b0;
      idx_q   <= '0;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      upper_q <= upper_d;
      idx_q   <= idx_d;
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

endmodule
